// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution for one IFM channel: two-row line buffer, 3x3 window,
// then a product stage and an adder-tree stage producing one OFM pixel per issued window.
module conv3x3_stream_engine #(
  parameter int DATA_W = 16,
  parameter int IFM_W  = 14,
  parameter int IFM_H  = 14,
  parameter int STRIDE = 1,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] In_IFM,
  input  logic [DATA_W-1:0] In_Weight,
  output logic              busy,
  output logic              out_valid,
  output logic [ACC_W-1:0]  Out_OFM
);

  localparam int PW = 2*DATA_W;
  localparam int CW = $clog2(IFM_W);
  localparam int RW = $clog2(IFM_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_relu;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [3:0]        r_wcnt;
  logic [DATA_W-1:0] r_wt  [9];
  logic [DATA_W-1:0] r_lb0 [IFM_W];
  logic [DATA_W-1:0] r_lb1 [IFM_W];
  logic [DATA_W-1:0] r_win [9];
  logic              r_win_vld;
  logic [PW-1:0]     r_prod [9];
  logic              r_prod_vld;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out;

  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_last;
  logic              w_ready;
  logic              w_wt_en;
  logic [3:0]        w_wt_idx;
  logic [ACC_W-1:0]  w_sum;
  logic              w_neg;

  function automatic logic [PW-1:0] f_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [PW-1:0] v_sa;
    logic signed [PW-1:0] v_sb;
    logic [PW-1:0]        v_ua;
    logic [PW-1:0]        v_ub;
    v_sa = PW'($signed(a));
    v_sb = PW'($signed(b));
    v_ua = PW'(a);
    v_ub = PW'(b);
    if (SIGNED != 0) begin
      f_mul = v_sa * v_sb;
    end else begin
      f_mul = v_ua * v_ub;
    end
  endfunction

  function automatic logic [ACC_W-1:0] f_ext(input logic [PW-1:0] p);
    logic signed [PW-1:0] v_sp;
    v_sp = $signed(p);
    if (SIGNED != 0) begin
      f_ext = ACC_W'(v_sp);
    end else begin
      f_ext = ACC_W'(p);
    end
  endfunction

  // In_IFM carries pixel (r_row, r_col) whenever a beat is accepted in IDLE or RUN
  assign w_accept   = in_valid && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_col_last = (r_col == CW'(IFM_W-1));
  assign w_row_last = (r_row == RW'(IFM_H-1));
  assign w_last     = w_col_last && w_row_last;
  assign w_ready    = (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                      ((STRIDE == 1) || !r_row[0]) && ((STRIDE == 1) || !r_col[0]);
  assign w_wt_en    = w_accept && ((r_state == S_IDLE) || (r_wcnt < 4'd9));
  assign w_wt_idx   = (r_state == S_IDLE) ? 4'd0 : r_wcnt;
  assign w_neg      = (SIGNED != 0) && r_relu && w_sum[ACC_W-1];

  always_comb begin
    w_sum = {ACC_W{1'b0}};
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + f_ext(r_prod[i]);
    end
  end

  // Frame FSM; DRAIN holds until both pipeline stages have emptied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_relu  <= relu_en;
          end
        end
        S_RUN: begin
          if (in_valid && w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_win_vld && !r_prod_vld) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= {CW{1'b0}};
      r_row  <= {RW{1'b0}};
      r_wcnt <= 4'd0;
      for (int i = 0; i < 9; i++) r_wt[i] <= {DATA_W{1'b0}};
    end else begin
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= {CW{1'b0}};
          r_row <= w_row_last ? {RW{1'b0}} : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_wt_en) begin
        r_wt[w_wt_idx] <= In_Weight;
        r_wcnt         <= w_wt_idx + 4'd1;
      end
    end
  end

  // Line buffers shift one column per beat; window index is row*3+col, row 0 oldest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IFM_W; i++) begin
        r_lb0[i] <= {DATA_W{1'b0}};
        r_lb1[i] <= {DATA_W{1'b0}};
      end
      for (int i = 0; i < 9; i++) r_win[i] <= {DATA_W{1'b0}};
      r_win_vld <= 1'b0;
    end else begin
      r_win_vld <= w_accept && w_ready;
      if (w_accept) begin
        r_lb1[r_col] <= r_lb0[r_col];
        r_lb0[r_col] <= In_IFM;
        for (int i = 0; i < 3; i++) begin
          r_win[i*3]   <= r_win[i*3+1];
          r_win[i*3+1] <= r_win[i*3+2];
        end
        r_win[2] <= r_lb1[r_col];
        r_win[5] <= r_lb0[r_col];
        r_win[8] <= In_IFM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_prod[i] <= {PW{1'b0}};
      r_prod_vld  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= {ACC_W{1'b0}};
    end else begin
      r_prod_vld  <= r_win_vld;
      r_out_valid <= r_prod_vld;
      if (r_win_vld) begin
        for (int i = 0; i < 9; i++) r_prod[i] <= f_mul(r_win[i], r_wt[i]);
      end
      if (r_prod_vld) begin
        r_out <= w_neg ? {ACC_W{1'b0}} : w_sum;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign Out_OFM   = r_out;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed bench: three engine instances (stride 1 unsigned, stride 2 unsigned, stride 1 signed)
// share one input stream; outputs are logged and compared against hand-derived values.
module tb_conv3x3_stream_engine;

  localparam int AW   = 36;
  localparam int W    = 14;
  localparam int H    = 14;
  localparam int NMAX = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        relu_en;
  logic [15:0] In_IFM;
  logic [15:0] In_Weight;
  logic [2:0]  busy_s;
  logic [2:0]  ov_s;
  logic [AW-1:0] oo_s [3];

  always #5 clk = ~clk;

  conv3x3_stream_engine #(.STRIDE(1), .SIGNED(0)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .relu_en(relu_en),
    .In_IFM(In_IFM), .In_Weight(In_Weight),
    .busy(busy_s[0]), .out_valid(ov_s[0]), .Out_OFM(oo_s[0]));

  conv3x3_stream_engine #(.STRIDE(2), .SIGNED(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .relu_en(relu_en),
    .In_IFM(In_IFM), .In_Weight(In_Weight),
    .busy(busy_s[1]), .out_valid(ov_s[1]), .Out_OFM(oo_s[1]));

  conv3x3_stream_engine #(.STRIDE(1), .SIGNED(1)) u_sg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .relu_en(relu_en),
    .In_IFM(In_IFM), .In_Weight(In_Weight),
    .busy(busy_s[2]), .out_valid(ov_s[2]), .Out_OFM(oo_s[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] ov_mem [3][NMAX];
  int            oc_mem [3][NMAX];
  int            on [3]       = '{0, 0, 0};
  int            fall_cyc [3] = '{0, 0, 0};
  logic [2:0]    prev_busy    = 3'b000;

  // Output logger: value and cycle of every out_valid, plus the cycle busy last fell
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov_s[k] && (on[k] < NMAX)) begin
        ov_mem[k][on[k]] <= oo_s[k];
        oc_mem[k][on[k]] <= cyc;
        on[k]            <= on[k] + 1;
      end
      if (prev_busy[k] && !busy_s[k]) fall_cyc[k] <= cyc;
    end
    prev_busy <= busy_s;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] wt [9];
  int          rb_cyc [NMAX];
  int          rb_n;
  int          st [3];

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] expval(input int test, input int k, input int r, input int c);
    case (test)
      1:       expval = 36'd9;
      2:       expval = AW'((r-1)*W + (c-1));
      3:       expval = (k == 2) ? 36'd0 : 36'h0_0008_FFF7;
      4:       expval = (k == 2) ? 36'hF_FFFF_FFF7 : 36'h0_0008_FFF7;
      5:       expval = (k == 2) ? 36'd9 : 36'h8_FFEE_0009;
      default: expval = 36'd0;
    endcase
  endfunction

  task automatic drive_frame(input int mode, input logic [15:0] val, input bit gaps, input int abort_at);
    rb_n = 0;
    for (int b = 0; b < W*H; b++) begin
      int r;
      int c;
      r = b / W;
      c = b % W;
      @(negedge clk);
      if (b == 1) chk("busy_after_first_beat", AW'(busy_s), AW'(3'b111));
      if (b == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        return;
      end
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      in_valid  = 1'b1;
      In_IFM    = (mode == 1) ? 16'(r*W + c) : val;
      In_Weight = (b < 9) ? wt[b] : 16'hBEEF;
      if ((r >= 2) && (c >= 2)) begin
        rb_cyc[rb_n] = cyc + 1;
        rb_n++;
      end
    end
    // One beat during DRAIN must be dropped
    @(negedge clk);
    In_IFM    = 16'h7777;
    In_Weight = 16'h7777;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_s == 3'b000) break;
    end
    chk("idle_within_bound", AW'(busy_s), AW'(3'b000));
    repeat (4) @(negedge clk);
  endtask

  task automatic check_dut(input int k, input int test, input int stride, input bit chk_cyc);
    int n;
    int idx;
    int last;
    n   = on[k] - st[k];
    idx = 0;
    chk($sformatf("t%0d_d%0d_count", test, k), AW'(n), AW'((stride == 1) ? 144 : 36));
    for (int r = 2; r < H; r += stride) begin
      for (int c = 2; c < W; c += stride) begin
        if (idx < n) begin
          chk($sformatf("t%0d_d%0d_val_r%0d_c%0d", test, k, r, c),
              ov_mem[k][st[k]+idx], expval(test, k, r, c));
          if (chk_cyc) chk($sformatf("t%0d_d%0d_lat_%0d", test, k, idx),
                           AW'(oc_mem[k][st[k]+idx] - rb_cyc[idx]), AW'(2));
        end
        idx++;
      end
    end
    if (n > 0) begin
      last = oc_mem[k][st[k]+n-1];
      if (stride == 1) chk($sformatf("t%0d_d%0d_busy_fall", test, k), AW'(fall_cyc[k]), AW'(last + 1));
      else             chk($sformatf("t%0d_d%0d_busy_after", test, k), AW'(fall_cyc[k] > last), AW'(1));
    end
  endtask

  task automatic mark();
    for (int k = 0; k < 3; k++) st[k] = on[k];
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    relu_en   = 1'b0;
    In_IFM    = 16'h0000;
    In_Weight = 16'h0000;
    for (int i = 0; i < 9; i++) wt[i] = 16'h0001;
    repeat (3) @(negedge clk);
    chk("reset_busy", AW'(busy_s), AW'(3'b000));
    chk("reset_out_valid", AW'(ov_s), AW'(3'b000));
    for (int k = 0; k < 3; k++) chk($sformatf("reset_ofm_d%0d", k), oo_s[k], 36'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: all ones
    mark();
    drive_frame(0, 16'h0001, 1'b0, -1);
    wait_idle();
    check_dut(0, 1, 1, 1'b1);
    check_dut(1, 1, 2, 1'b0);
    check_dut(2, 1, 1, 1'b0);

    // T2/T3: ramp with centre tap only
    for (int i = 0; i < 9; i++) wt[i] = 16'h0000;
    wt[4] = 16'h0001;
    mark();
    drive_frame(1, 16'h0000, 1'b0, -1);
    wait_idle();
    check_dut(0, 2, 1, 1'b1);
    check_dut(1, 2, 2, 1'b0);
    check_dut(2, 2, 1, 1'b0);

    // T4: pixels -1 / 0xFFFF, ReLU on then off
    for (int i = 0; i < 9; i++) wt[i] = 16'h0001;
    relu_en = 1'b1;
    mark();
    drive_frame(0, 16'hFFFF, 1'b0, -1);
    wait_idle();
    check_dut(0, 3, 1, 1'b0);
    check_dut(1, 3, 2, 1'b0);
    check_dut(2, 3, 1, 1'b0);
    relu_en = 1'b0;
    mark();
    drive_frame(0, 16'hFFFF, 1'b0, -1);
    wait_idle();
    check_dut(0, 4, 1, 1'b0);
    check_dut(2, 4, 1, 1'b0);

    // T5: all ones with random stalls
    mark();
    drive_frame(0, 16'h0001, 1'b1, -1);
    wait_idle();
    check_dut(0, 1, 1, 1'b1);
    check_dut(1, 1, 2, 1'b0);

    // T6: reset at beat 100, then a fresh frame
    drive_frame(0, 16'h0001, 1'b0, 100);
    repeat (2) @(negedge clk);
    chk("abort_busy", AW'(busy_s), AW'(3'b000));
    chk("abort_out_valid", AW'(ov_s), AW'(3'b000));
    chk("abort_ofm_d0", oo_s[0], 36'd0);
    mark();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("abort_no_out_d%0d", k), AW'(on[k] - st[k]), AW'(0));
    mark();
    drive_frame(0, 16'h0001, 1'b0, -1);
    wait_idle();
    check_dut(0, 1, 1, 1'b1);
    check_dut(2, 1, 1, 1'b0);

    // Maximum operands
    for (int i = 0; i < 9; i++) wt[i] = 16'hFFFF;
    mark();
    drive_frame(0, 16'hFFFF, 1'b0, -1);
    wait_idle();
    check_dut(0, 5, 1, 1'b0);
    check_dut(1, 5, 2, 1'b0);
    check_dut(2, 5, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
